// File: rtl/vga_grid_pkg.sv
// rtl/vga_grid_pkg.sv - shared colours, cell/FSM encodings and VGA visible-area defaults
package vga_grid_pkg;

    localparam logic [11:0] BLACK  = 12'h000;
    localparam logic [11:0] WHITE  = 12'hFFF;
    localparam logic [11:0] BLUE   = 12'h00F;
    localparam logic [11:0] RED    = 12'hF00;
    localparam logic [11:0] GRAY   = 12'h888;
    localparam logic [11:0] YELLOW = 12'hFF0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        HIT   = 2'd2,
        MISS  = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE_RD = 2'd1,
        FIRE_WR = 2'd2,
        CLEAR   = 2'd3
    } fsm_t;

    localparam int H_VIS_START = 144;
    localparam int V_VIS_START = 35;
    localparam int H_VIS       = 640;
    localparam int V_VIS       = 480;

endpackage

// File: rtl/vga_grid_board_mapper.sv
// rtl/vga_grid_board_mapper.sv - maps the raster position to grid cell, line and border flags
module grid_pixel_mapper
    import vga_grid_pkg::*;
#(
    parameter int GRID_COLS = 10,
    parameter int GRID_ROWS = 10,
    parameter int CELL_W    = 64,
    parameter int CELL_H    = 48,
    parameter int GRID_LEFT = H_VIS_START,
    parameter int GRID_TOP  = V_VIS_START,
    parameter int LINE_W    = 1,
    localparam int COL_W    = $clog2(GRID_COLS),
    localparam int ROW_W    = $clog2(GRID_ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       i_hcount,
    input  logic [9:0]       i_vcount,
    output logic             o_in_grid,
    output logic             o_on_line,
    output logic             o_in_cell_border,
    output logic [COL_W-1:0] o_pix_col,
    output logic [ROW_W-1:0] o_pix_row
);

    // Column/row counters carry one extra value (GRID_COLS / GRID_ROWS) for the closing line.
    localparam int XC_W = $clog2(GRID_COLS + 1);
    localparam int YC_W = $clog2(GRID_ROWS + 1);
    localparam int XO_W = $clog2(CELL_W);
    localparam int YO_W = $clog2(CELL_H);

    // State of the previous pixel; the current pixel is derived from it by a single step.
    logic [9:0]      r_hprev;
    logic [9:0]      r_vprev;
    logic            r_x_in;
    logic [XC_W-1:0] r_x_col;
    logic [XO_W-1:0] r_x_off;
    logic            r_y_in;
    logic [YC_W-1:0] r_y_row;
    logic [YO_W-1:0] r_y_off;

    logic            w_x_in;
    logic [XC_W-1:0] w_x_col;
    logic [XO_W-1:0] w_x_off;
    logic            w_y_in;
    logic [YC_W-1:0] w_y_row;
    logic [YO_W-1:0] w_y_off;
    logic            w_x_line;
    logic            w_y_line;
    logic            w_x_band;
    logic            w_y_band;

    // Horizontal: restart at GRID_LEFT, hold on a repeated hCount, step on hCount+1, drop out on any jump.
    always_comb begin
        w_x_in  = 1'b0;
        w_x_col = '0;
        w_x_off = '0;
        if (int'(i_hcount) == GRID_LEFT) begin
            w_x_in = 1'b1;
        end else if (i_hcount == r_hprev) begin
            w_x_in  = r_x_in;
            w_x_col = r_x_col;
            w_x_off = r_x_off;
        end else if ((i_hcount == r_hprev + 10'd1) && r_x_in) begin
            if (int'(r_x_col) == GRID_COLS) begin
                if (int'(r_x_off) + 1 < LINE_W) begin
                    w_x_in  = 1'b1;
                    w_x_col = r_x_col;
                    w_x_off = r_x_off + XO_W'(1);
                end
            end else if (int'(r_x_off) == CELL_W - 1) begin
                w_x_in  = 1'b1;
                w_x_col = r_x_col + XC_W'(1);
            end else begin
                w_x_in  = 1'b1;
                w_x_col = r_x_col;
                w_x_off = r_x_off + XO_W'(1);
            end
        end
    end

    // Vertical: same stepping rule on vCount, which changes once per line.
    always_comb begin
        w_y_in  = 1'b0;
        w_y_row = '0;
        w_y_off = '0;
        if (int'(i_vcount) == GRID_TOP) begin
            w_y_in = 1'b1;
        end else if (i_vcount == r_vprev) begin
            w_y_in  = r_y_in;
            w_y_row = r_y_row;
            w_y_off = r_y_off;
        end else if ((i_vcount == r_vprev + 10'd1) && r_y_in) begin
            if (int'(r_y_row) == GRID_ROWS) begin
                if (int'(r_y_off) + 1 < LINE_W) begin
                    w_y_in  = 1'b1;
                    w_y_row = r_y_row;
                    w_y_off = r_y_off + YO_W'(1);
                end
            end else if (int'(r_y_off) == CELL_H - 1) begin
                w_y_in  = 1'b1;
                w_y_row = r_y_row + YC_W'(1);
            end else begin
                w_y_in  = 1'b1;
                w_y_row = r_y_row;
                w_y_off = r_y_off + YO_W'(1);
            end
        end
    end

    // Remember this pixel's position so the next one can be stepped from it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hprev <= '0;
            r_vprev <= '0;
            r_x_in  <= 1'b0;
            r_x_col <= '0;
            r_x_off <= '0;
            r_y_in  <= 1'b0;
            r_y_row <= '0;
            r_y_off <= '0;
        end else begin
            r_hprev <= i_hcount;
            r_vprev <= i_vcount;
            r_x_in  <= w_x_in;
            r_x_col <= w_x_col;
            r_x_off <= w_x_off;
            r_y_in  <= w_y_in;
            r_y_row <= w_y_row;
            r_y_off <= w_y_off;
        end
    end

    // The closing zone only ever has offsets below LINE_W, so it always reads as a line.
    assign w_x_line = (int'(w_x_off) < LINE_W);
    assign w_y_line = (int'(w_y_off) < LINE_W);
    assign w_x_band = (int'(w_x_off) < 2 * LINE_W) || (int'(w_x_off) >= CELL_W - LINE_W);
    assign w_y_band = (int'(w_y_off) < 2 * LINE_W) || (int'(w_y_off) >= CELL_H - LINE_W);

    assign o_in_grid        = w_x_in && w_y_in;
    assign o_on_line        = o_in_grid && (w_x_line || w_y_line);
    assign o_in_cell_border = o_in_grid && !o_on_line && (w_x_band || w_y_band);
    assign o_pix_col        = w_x_col[COL_W-1:0];
    assign o_pix_row        = w_y_row[ROW_W-1:0];

endmodule

// File: rtl/vga_grid_board.sv
// rtl/vga_grid_board.sv - battleship board state engine and VGA renderer
module vga_grid_board
    import vga_grid_pkg::*;
#(
    parameter int GRID_COLS  = 10,
    parameter int GRID_ROWS  = 10,
    parameter int CELL_W     = 64,
    parameter int CELL_H     = 48,
    parameter int GRID_LEFT  = H_VIS_START,
    parameter int GRID_TOP   = V_VIS_START,
    parameter int LINE_W     = 1,
    parameter int SHOW_SHIPS = 0,
    localparam int COL_W     = $clog2(GRID_COLS),
    localparam int ROW_W     = $clog2(GRID_ROWS),
    localparam int N_CELLS   = GRID_COLS * GRID_ROWS,
    localparam int CNT_W     = $clog2(N_CELLS + 1),
    localparam int IDX_W     = $clog2(N_CELLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bright,
    input  logic [9:0]       hCount,
    input  logic [9:0]       vCount,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_fire,
    input  logic             clear,
    input  logic             place_we,
    input  logic [COL_W-1:0] place_col,
    input  logic [ROW_W-1:0] place_row,
    output logic [11:0]      rgb,
    output logic [15:0]      score,
    output logic [CNT_W-1:0] ships_left,
    output logic             busy,
    output logic             shot_done,
    output logic             shot_hit,
    output logic             game_over
);

    fsm_t             r_state;
    fsm_t             w_state_nx;
    cell_t            r_cells [N_CELLS];
    cell_t            r_rd_cell;
    logic [COL_W-1:0] r_cur_col;
    logic [ROW_W-1:0] r_cur_row;
    logic [IDX_W-1:0] r_clr_idx;
    logic [15:0]      r_score;
    logic [CNT_W-1:0] r_ships;
    logic             r_shot_done;
    logic             r_shot_hit;
    logic [11:0]      r_rgb;

    logic [IDX_W-1:0] w_cur_idx;
    logic [IDX_W-1:0] w_place_idx;
    logic             w_place_rng;
    logic             w_place_ok;
    logic             w_place_go;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    cell_t            w_wr_val;
    logic             w_hit;
    logic             w_shot_end;
    logic             w_clr_last;

    logic             w_in_grid;
    logic             w_on_line;
    logic             w_border;
    logic [COL_W-1:0] w_pix_col;
    logic [ROW_W-1:0] w_pix_row;
    int               w_pix_idx;
    cell_t            w_pix_cell;
    logic [11:0]      w_rgb_nx;

    assign w_cur_idx   = IDX_W'(int'(r_cur_row) * GRID_COLS + int'(r_cur_col));
    assign w_place_rng = (int'(place_col) < GRID_COLS) && (int'(place_row) < GRID_ROWS);
    assign w_place_idx = w_place_rng ? IDX_W'(int'(place_row) * GRID_COLS + int'(place_col)) : '0;
    assign w_place_ok  = w_place_rng && (r_cells[w_place_idx] == EMPTY);

    assign busy       = (r_state != IDLE);
    assign game_over  = (r_ships == '0) && (r_score != 16'd0);
    assign score      = r_score;
    assign ships_left = r_ships;
    assign shot_done  = r_shot_done;
    assign shot_hit   = r_shot_hit;
    assign rgb        = r_rgb;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state plus the single cell-write port and counter strobes it drives.
    always_comb begin
        w_state_nx = r_state;
        w_place_go = 1'b0;
        w_wr_en    = 1'b0;
        w_wr_idx   = w_cur_idx;
        w_wr_val   = EMPTY;
        w_hit      = 1'b0;
        w_shot_end = 1'b0;
        w_clr_last = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear) begin
                    w_state_nx = CLEAR;
                end else if (btn_fire && !game_over) begin
                    w_state_nx = FIRE_RD;
                end else if (place_we && w_place_ok) begin
                    w_wr_en    = 1'b1;
                    w_wr_idx   = w_place_idx;
                    w_wr_val   = SHIP;
                    w_place_go = 1'b1;
                end
            end
            FIRE_RD: begin
                w_state_nx = FIRE_WR;
            end
            FIRE_WR: begin
                w_state_nx = IDLE;
                w_shot_end = 1'b1;
                case (r_rd_cell)
                    SHIP: begin
                        w_wr_en  = 1'b1;
                        w_wr_val = HIT;
                        w_hit    = 1'b1;
                    end
                    EMPTY: begin
                        w_wr_en  = 1'b1;
                        w_wr_val = MISS;
                    end
                    default: w_wr_en = 1'b0;
                endcase
            end
            CLEAR: begin
                w_wr_en  = 1'b1;
                w_wr_idx = r_clr_idx;
                w_wr_val = EMPTY;
                if (int'(r_clr_idx) == N_CELLS - 1) begin
                    w_clr_last = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Cell array with its one write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CELLS; i++) begin
                r_cells[i] <= EMPTY;
            end
        end else if (w_wr_en) begin
            r_cells[w_wr_idx] <= w_wr_val;
        end
    end

    // Shot latch, wipe index, score/ship counters and shot result pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_cell   <= EMPTY;
            r_clr_idx   <= '0;
            r_score     <= 16'd0;
            r_ships     <= '0;
            r_shot_done <= 1'b0;
            r_shot_hit  <= 1'b0;
        end else begin
            if (r_state == FIRE_RD) begin
                r_rd_cell <= r_cells[w_cur_idx];
            end
            r_clr_idx <= (r_state == CLEAR) ? r_clr_idx + IDX_W'(1) : '0;
            if (w_clr_last) begin
                r_score <= 16'd0;
                r_ships <= '0;
            end else if (w_hit) begin
                if (r_score != 16'hFFFF) begin
                    r_score <= r_score + 16'd1;
                end
                r_ships <= r_ships - CNT_W'(1);
            end else if (w_place_go) begin
                r_ships <= r_ships + CNT_W'(1);
            end
            r_shot_done <= w_shot_end;
            r_shot_hit  <= w_hit;
        end
    end

    // Cursor moves only in IDLE; opposite buttons on one axis cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_col <= '0;
            r_cur_row <= '0;
        end else if (r_state == IDLE) begin
            if (btn_left && !btn_right) begin
                r_cur_col <= (r_cur_col == '0) ? COL_W'(GRID_COLS - 1) : r_cur_col - COL_W'(1);
            end else if (btn_right && !btn_left) begin
                r_cur_col <= (int'(r_cur_col) == GRID_COLS - 1) ? '0 : r_cur_col + COL_W'(1);
            end
            if (btn_up && !btn_down) begin
                r_cur_row <= (r_cur_row == '0) ? ROW_W'(GRID_ROWS - 1) : r_cur_row - ROW_W'(1);
            end else if (btn_down && !btn_up) begin
                r_cur_row <= (int'(r_cur_row) == GRID_ROWS - 1) ? '0 : r_cur_row + ROW_W'(1);
            end
        end
    end

    grid_pixel_mapper #(
        .GRID_COLS (GRID_COLS),
        .GRID_ROWS (GRID_ROWS),
        .CELL_W    (CELL_W),
        .CELL_H    (CELL_H),
        .GRID_LEFT (GRID_LEFT),
        .GRID_TOP  (GRID_TOP),
        .LINE_W    (LINE_W)
    ) u_mapper (
        .clk              (clk),
        .reset            (reset),
        .i_hcount         (hCount),
        .i_vcount         (vCount),
        .o_in_grid        (w_in_grid),
        .o_on_line        (w_on_line),
        .o_in_cell_border (w_border),
        .o_pix_col        (w_pix_col),
        .o_pix_row        (w_pix_row)
    );

    assign w_pix_idx  = int'(w_pix_row) * GRID_COLS + int'(w_pix_col);
    assign w_pix_cell = (w_in_grid && !w_on_line && (w_pix_idx < N_CELLS)) ?
                        r_cells[IDX_W'(w_pix_idx)] : EMPTY;

    // Pixel colour by render priority.
    always_comb begin
        w_rgb_nx = BLACK;
        if (!bright) begin
            w_rgb_nx = BLACK;
        end else if (w_border && (w_pix_col == r_cur_col) && (w_pix_row == r_cur_row)) begin
            w_rgb_nx = YELLOW;
        end else if (w_on_line) begin
            w_rgb_nx = WHITE;
        end else if (w_in_grid) begin
            case (w_pix_cell)
                HIT:     w_rgb_nx = RED;
                MISS:    w_rgb_nx = WHITE;
                SHIP:    w_rgb_nx = (SHOW_SHIPS != 0) ? GRAY : BLUE;
                default: w_rgb_nx = BLUE;
            endcase
        end
    end

    // One-cycle registered pixel output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb <= BLACK;
        end else begin
            r_rgb <= w_rgb_nx;
        end
    end

endmodule
